// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tpu_pkg
// Purpose  : Shared TPU types: datapath words/bytes, activation function
//            codes, the activation instruction record and the activation
//            controller state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tpu_pkg;

  localparam int ACC_ADDR_W    = 9;
  localparam int BUFFER_ADDR_W = 12;
  localparam int LENGTH_W      = 16;

  typedef logic [31:0] word_type;
  typedef logic [7:0]  byte_type;

  typedef enum logic [1:0] {
    no_activation = 2'd0,
    relu          = 2'd1,
    sigmoid       = 2'd2
  } activation_type;

  // "function" and "signed" are reserved words, hence the act_ prefix.
  typedef struct packed {
    logic [ACC_ADDR_W-1:0]    acc_addr;
    logic [BUFFER_ADDR_W-1:0] buffer_addr;
    logic [LENGTH_W-1:0]      length;
    activation_type           act_function;
    logic                     act_signed;
  } activation_instr_type;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } act_ctrl_state_type;

  // Saturating 32-bit increment for event counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/act_ctrl_delay_pipe.sv
`default_nettype none
// ============================================================================
// Module   : act_ctrl_delay_pipe
// Purpose  : DEPTH-stage shift register carrying (valid, buffer address) so a
//            read issued in cycle k emerges as a write in cycle k+DEPTH.
// Ports    : clk, rst (async, active-low)
//            in_valid / in_addr   - entry pushed this cycle
//            out_valid / out_addr - entry leaving the last stage
//            pending              - valid entries still behind the last stage
// Revision : 1.0 - initial release
// ============================================================================
module act_ctrl_delay_pipe #(
  parameter int DEPTH      = 3,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  pending
);

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];

  always_comb begin
    valid_d[0] = in_valid;
    addr_d[0]  = in_addr;
    for (int j = 1; j < DEPTH; j++) begin
      valid_d[j] = valid_q[j-1];
      addr_d[j]  = addr_q[j-1];
    end
  end

  // The entry in the last stage is being written right now; anything in an
  // earlier stage still has a write ahead of it.
  always_comb begin
    pending = 1'b0;
    for (int j = 0; j < DEPTH - 1; j++) begin
      pending = pending | valid_q[j];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int j = 0; j < DEPTH; j++) addr_q[j] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int j = 0; j < DEPTH; j++) addr_q[j] <= addr_d[j];
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_addr  = addr_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/activation_control.sv
`default_nettype none
// ============================================================================
// Module   : activation_control
// Purpose  : Sequencer for the activation datapath. Takes one instruction at a
//            time, issues one accumulator read per cycle, keeps the activation
//            unit enabled and configured, and writes the result rows to the
//            unified buffer after the fixed read + activation latency.
// Ports    : clk, rst (async, active-low)
//            instr_*      - instruction handshake and fields
//            acc_rd_*     - accumulator read strobe/address
//            act_*        - activation unit enable/function/signedness
//            buf_wr_*     - unified buffer write strobe/address
//            busy, done   - status
//            perf_rows, perf_busy_cycles - only with ACTIVATION_CONTROL_PERF_EN
// Options  : `define ACTIVATION_CONTROL_PERF_EN adds saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module activation_control
  import tpu_pkg::*;
#(
  parameter int ACC_ADDR_WIDTH     = 9,
  parameter int BUFFER_ADDR_WIDTH  = 12,
  parameter int LENGTH_WIDTH       = 16,
  parameter int ACC_READ_LATENCY   = 1,
  parameter int ACTIVATION_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic [ACC_ADDR_WIDTH-1:0]    instr_acc_addr,
  input  logic [BUFFER_ADDR_WIDTH-1:0] instr_buffer_addr,
  input  logic [LENGTH_WIDTH-1:0]      instr_length,
  input  activation_type               instr_function,
  input  logic                         instr_signed,
  output logic                         acc_rd_en,
  output logic [ACC_ADDR_WIDTH-1:0]    acc_rd_addr,
  output logic                         act_enable,
  output activation_type               act_function,
  output logic                         act_signed,
  output logic                         buf_wr_en,
  output logic [BUFFER_ADDR_WIDTH-1:0] buf_wr_addr,
  output logic                         busy,
  output logic                         done
`ifdef ACTIVATION_CONTROL_PERF_EN
  ,
  output logic [31:0]                  perf_rows,
  output logic [31:0]                  perf_busy_cycles
`endif
);

  localparam int PIPE = ACC_READ_LATENCY + ACTIVATION_LATENCY;

  act_ctrl_state_type              state_q, state_d;
  logic                            acc_rd_en_q, acc_rd_en_d;
  logic [ACC_ADDR_WIDTH-1:0]       acc_rd_addr_q, acc_rd_addr_d;
  logic [BUFFER_ADDR_WIDTH-1:0]    buf_addr_q, buf_addr_d;
  logic [LENGTH_WIDTH-1:0]         remaining_q, remaining_d;
  activation_type                  act_function_q, act_function_d;
  logic                            act_signed_q, act_signed_d;
  logic                            pipe_pending;

  // ---------------------------------------------------------------------------
  // Next-state and datapath control. remaining_q counts rows still to issue
  // after the one currently on acc_rd_addr, so it hits zero on the last row.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    acc_rd_en_d    = acc_rd_en_q;
    acc_rd_addr_d  = acc_rd_addr_q;
    buf_addr_d     = buf_addr_q;
    remaining_d    = remaining_q;
    act_function_d = act_function_q;
    act_signed_d   = act_signed_q;

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          act_function_d = instr_function;
          act_signed_d   = instr_signed;
          if (instr_length == '0) begin
            state_d = DONE;
          end else begin
            state_d       = ISSUE;
            acc_rd_en_d   = 1'b1;
            acc_rd_addr_d = instr_acc_addr;
            buf_addr_d    = instr_buffer_addr;
            remaining_d   = instr_length - LENGTH_WIDTH'(1);
          end
        end
      end
      ISSUE: begin
        // buf_addr_q is paired with the read on the bus this cycle.
        buf_addr_d = buf_addr_q + BUFFER_ADDR_WIDTH'(1);
        if (remaining_q == '0) begin
          acc_rd_en_d = 1'b0;
          state_d     = DRAIN;
        end else begin
          acc_rd_addr_d = acc_rd_addr_q + ACC_ADDR_WIDTH'(1);
          remaining_d   = remaining_q - LENGTH_WIDTH'(1);
        end
      end
      DRAIN: begin
        // Leave once only the final write (if any) is left in the last stage.
        if (!pipe_pending) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        acc_rd_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      acc_rd_en_q    <= 1'b0;
      acc_rd_addr_q  <= '0;
      buf_addr_q     <= '0;
      remaining_q    <= '0;
      act_function_q <= no_activation;
      act_signed_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_rd_en_q    <= acc_rd_en_d;
      acc_rd_addr_q  <= acc_rd_addr_d;
      buf_addr_q     <= buf_addr_d;
      remaining_q    <= remaining_d;
      act_function_q <= act_function_d;
      act_signed_q   <= act_signed_d;
    end
  end

  act_ctrl_delay_pipe #(
    .DEPTH      (PIPE),
    .ADDR_WIDTH (BUFFER_ADDR_WIDTH)
  ) u_delay_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (acc_rd_en_q),
    .in_addr   (buf_addr_q),
    .out_valid (buf_wr_en),
    .out_addr  (buf_wr_addr),
    .pending   (pipe_pending)
  );

  assign instr_ready  = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  // ISSUE plus DRAIN spans first read through last write exactly.
  assign act_enable   = (state_q == ISSUE) || (state_q == DRAIN);
  assign acc_rd_en    = acc_rd_en_q;
  assign acc_rd_addr  = acc_rd_addr_q;
  assign act_function = act_function_q;
  assign act_signed   = act_signed_q;

`ifdef ACTIVATION_CONTROL_PERF_EN
  logic [31:0] perf_rows_q, perf_rows_d;
  logic [31:0] perf_busy_cycles_q, perf_busy_cycles_d;

  always_comb begin
    perf_rows_d        = buf_wr_en ? sat_inc32(perf_rows_q) : perf_rows_q;
    perf_busy_cycles_d = busy ? sat_inc32(perf_busy_cycles_q) : perf_busy_cycles_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_rows_q        <= '0;
      perf_busy_cycles_q <= '0;
    end else begin
      perf_rows_q        <= perf_rows_d;
      perf_busy_cycles_q <= perf_busy_cycles_d;
    end
  end

  assign perf_rows        = perf_rows_q;
  assign perf_busy_cycles = perf_busy_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_activation_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_activation_control
// Purpose  : Directed self-checking bench for activation_control. Each
//            instruction is driven and every cycle of it is compared against
//            hand-derived timing: reads in cycles 1..n after accept, writes
//            PIPE cycles later, done at n+PIPE+1 (cycle 1 for n=0).
// Ports    : none
// Options  : ACTIVATION_CONTROL_PERF_EN also checks the perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_activation_control;
  import tpu_pkg::*;

  localparam int PIPE     = 3;
  localparam int ACC_MASK = 511;
  localparam int BUF_MASK = 4095;

  logic           clk = 1'b0;
  logic           rst;
  logic           instr_valid;
  logic           instr_ready;
  logic [8:0]     instr_acc_addr;
  logic [11:0]    instr_buffer_addr;
  logic [15:0]    instr_length;
  activation_type instr_function;
  logic           instr_signed;
  logic           acc_rd_en;
  logic [8:0]     acc_rd_addr;
  logic           act_enable;
  activation_type act_function;
  logic           act_signed;
  logic           buf_wr_en;
  logic [11:0]    buf_wr_addr;
  logic           busy;
  logic           done;
`ifdef ACTIVATION_CONTROL_PERF_EN
  logic [31:0]    perf_rows;
  logic [31:0]    perf_busy_cycles;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  activation_control dut (
    .clk               (clk),
    .rst               (rst),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .instr_acc_addr    (instr_acc_addr),
    .instr_buffer_addr (instr_buffer_addr),
    .instr_length      (instr_length),
    .instr_function    (instr_function),
    .instr_signed      (instr_signed),
    .acc_rd_en         (acc_rd_en),
    .acc_rd_addr       (acc_rd_addr),
    .act_enable        (act_enable),
    .act_function      (act_function),
    .act_signed        (act_signed),
    .buf_wr_en         (buf_wr_en),
    .buf_wr_addr       (buf_wr_addr),
    .busy              (busy),
    .done              (done)
`ifdef ACTIVATION_CONTROL_PERF_EN
    ,
    .perf_rows         (perf_rows),
    .perf_busy_cycles  (perf_busy_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, " instr_ready"}, 32'(instr_ready), 1);
    chk({pfx, " busy"},        32'(busy), 0);
    chk({pfx, " done"},        32'(done), 0);
    chk({pfx, " acc_rd_en"},   32'(acc_rd_en), 0);
    chk({pfx, " acc_rd_addr"}, 32'(acc_rd_addr), 0);
    chk({pfx, " buf_wr_en"},   32'(buf_wr_en), 0);
    chk({pfx, " buf_wr_addr"}, 32'(buf_wr_addr), 0);
    chk({pfx, " act_enable"},  32'(act_enable), 0);
    chk({pfx, " act_function"}, 32'(act_function), 32'(no_activation));
    chk({pfx, " act_signed"},  32'(act_signed), 0);
  endtask

  // Drives one instruction from cycle 0 and checks every following cycle.
  // stop_c > 0 ends the run early at that cycle; offer_next presents another
  // instruction from cycle 1 on and leaves it valid at the end.
  task automatic run_instr(input string name, input int acc, input int bf, input int len,
                           input activation_type fn, input bit sg, input int stop_c,
                           input bit offer_next, input int nacc, input int nbf,
                           input int nlen, input activation_type nfn, input bit nsg);
    int done_c;
    int last_c;
    bit rd, wr;
    string t;
    done_c = (len == 0) ? 1 : len + PIPE + 1;
    last_c = (stop_c > 0) ? stop_c : done_c + 1;
    chk({name, " c0 instr_ready"}, 32'(instr_ready), 1);
    instr_acc_addr    = 9'(acc);
    instr_buffer_addr = 12'(bf);
    instr_length      = 16'(len);
    instr_function    = fn;
    instr_signed      = sg;
    instr_valid       = 1'b1;
    for (int c = 1; c <= last_c; c++) begin
      tick();
      if (c == 1) begin
        if (offer_next) begin
          instr_acc_addr    = 9'(nacc);
          instr_buffer_addr = 12'(nbf);
          instr_length      = 16'(nlen);
          instr_function    = nfn;
          instr_signed      = nsg;
        end else begin
          instr_valid = 1'b0;
        end
      end
      t  = $sformatf("%s c%0d", name, c);
      rd = (c <= len);
      wr = (c >= 1 + PIPE) && (c <= len + PIPE);
      chk({t, " acc_rd_en"}, 32'(acc_rd_en), 32'(rd));
      if (rd) chk({t, " acc_rd_addr"}, 32'(acc_rd_addr), (acc + c - 1) & ACC_MASK);
      chk({t, " buf_wr_en"}, 32'(buf_wr_en), 32'(wr));
      if (wr) chk({t, " buf_wr_addr"}, 32'(buf_wr_addr), (bf + c - 1 - PIPE) & BUF_MASK);
      chk({t, " act_enable"}, 32'(act_enable), 32'((len > 0) && (c <= len + PIPE)));
      chk({t, " done"}, 32'(done), 32'(c == done_c));
      chk({t, " busy"}, 32'(busy), 32'(c <= done_c));
      chk({t, " instr_ready"}, 32'(instr_ready), 32'(c > done_c));
      if (c <= done_c) begin
        chk({t, " act_function"}, 32'(act_function), 32'(fn));
        chk({t, " act_signed"}, 32'(act_signed), 32'(sg));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b0;
    instr_valid       = 1'b0;
    instr_acc_addr    = '0;
    instr_buffer_addr = '0;
    instr_length      = '0;
    instr_function    = no_activation;
    instr_signed      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Basic: 4 rows, relu, signed.
    run_instr("basic", 10, 100, 4, relu, 1'b1, 0, 1'b0, 0, 0, 0, no_activation, 1'b0);
    // Zero length: done straight away, no traffic.
    run_instr("len0", 0, 0, 0, sigmoid, 1'b0, 0, 1'b0, 0, 0, 0, no_activation, 1'b0);
    // Both counters wrap.
    run_instr("wrap", 510, 4094, 4, relu, 1'b0, 0, 1'b0, 0, 0, 0, no_activation, 1'b0);
    // Second instruction offered while busy; taken only after done.
    run_instr("first", 20, 300, 3, relu, 1'b1, 0, 1'b1, 40, 500, 2, sigmoid, 1'b0);
    run_instr("second", 40, 500, 2, sigmoid, 1'b0, 0, 1'b0, 0, 0, 0, no_activation, 1'b0);

    // Abort during DRAIN (cycle 9 of a length-8 run, writes still due).
    run_instr("abort", 0, 200, 8, relu, 1'b1, 9, 1'b0, 0, 0, 0, no_activation, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("abort_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_abort c%0d buf_wr_en", i), 32'(buf_wr_en), 0);
      chk($sformatf("post_abort c%0d busy", i), 32'(busy), 0);
    end

    // New instructions accepted after release (length 5 then 3).
    run_instr("after5", 5, 7, 5, relu, 1'b0, 0, 1'b0, 0, 0, 0, no_activation, 1'b0);
    run_instr("after3", 100, 9, 3, no_activation, 1'b1, 0, 1'b0, 0, 0, 0, no_activation, 1'b0);
`ifdef ACTIVATION_CONTROL_PERF_EN
    chk("perf_rows", perf_rows, 8);
    chk("perf_busy_cycles", perf_busy_cycles, 16);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/activation_control.md
Name: activation_control

Overview:
- Sequencer for the activation datapath. Accepts one activation instruction at a time and streams accumulator rows through the `activation` unit.
- Issues accumulator read addresses, drives the activation unit's `enable`, `activation_function` and `is_signed`, and writes the resulting byte rows to the unified buffer after the fixed pipeline delay.
- Sits between the instruction decoder and the accumulator/activation/unified-buffer datapath.

Parameters:
- ACC_ADDR_WIDTH, 9, accumulator row address width; addresses wrap modulo 2**ACC_ADDR_WIDTH.
- BUFFER_ADDR_WIDTH, 12, unified buffer row address width; addresses wrap modulo 2**BUFFER_ADDR_WIDTH.
- LENGTH_WIDTH, 16, width of the row-count field.
- ACC_READ_LATENCY, 1, cycles from `acc_rd_en` until the row is valid at the activation `data_in`.
- ACTIVATION_LATENCY, 2, cycles from activation `data_in` to `data_out`.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous reset, active-low.
- instr_valid, in, 1, instruction offered.
- instr_ready, out, 1, controller accepts an instruction (high only in IDLE).
- instr_acc_addr, in, ACC_ADDR_WIDTH, first accumulator row.
- instr_buffer_addr, in, BUFFER_ADDR_WIDTH, first unified buffer row.
- instr_length, in, LENGTH_WIDTH, number of rows.
- instr_function, in, activation_type, function to apply.
- instr_signed, in, 1, signed interpretation.
- acc_rd_en, out, 1, accumulator read strobe.
- acc_rd_addr, out, ACC_ADDR_WIDTH, accumulator read address.
- act_enable, out, 1, activation unit enable.
- act_function, out, activation_type, function latched for the current instruction.
- act_signed, out, 1, signedness latched for the current instruction.
- buf_wr_en, out, 1, unified buffer write strobe.
- buf_wr_addr, out, BUFFER_ADDR_WIDTH, unified buffer write address.
- busy, out, 1, high while not IDLE.
- done, out, 1, one-cycle pulse on completion.

Behaviour:
- Reset values (while rst=0): state IDLE, instr_ready=1, all strobes 0, addresses 0, act_function=no_activation, act_signed=0, busy=0, done=0. The delay pipe is cleared.
- Reset mid-operation aborts immediately. No further `buf_wr_en` occurs from the aborted instruction.
- PIPE = ACC_READ_LATENCY + ACTIVATION_LATENCY.
- **IDLE**
  - On instr_valid & instr_ready: latch function, signedness, both base addresses and the length.
  - length=0 → go to DONE (no reads, no writes). Otherwise → ISSUE.
- **ISSUE**
  - One row per cycle: acc_rd_en=1, acc_rd_addr = base+i, for i = 0..length-1 (registered outputs).
  - After the last row is issued → DRAIN.
- **DRAIN**
  - Waits until the delay pipe is empty → DONE.
- **DONE**
  - done=1 for exactly one cycle → IDLE.
  - instr_ready returns high in the cycle after DONE.
- **Delay pipe**
  - A PIPE-deep shift register carries (valid, buffer address).
  - A read issued in cycle k produces buf_wr_en=1 in cycle k+PIPE, with buf_wr_addr = buffer base + i.
  - Writes are contiguous, with no bubbles.
- act_enable is high from the first ISSUE cycle until the last write cycle inclusive; otherwise 0.
- act_function and act_signed are held stable for the whole instruction.
- Both address counters wrap around silently (e.g. acc base 511 with length 2 → reads 511 then 0).
- Total cycles from accept to done for length n ≥ 1: n + PIPE + 1.
- instr_valid while busy is ignored (instr_ready=0). The instruction fields must stay stable until accepted.
- No backpressure: the downstream buffer is always able to accept writes.

Optional Feature:
- Macro: ACTIVATION_CONTROL_PERF_EN.
- When defined, adds these outputs:
  - perf_rows (32-bit): total buffer writes since reset.
  - perf_busy_cycles (32-bit): cycles with busy=1.
  - Both saturate at all-ones and clear on reset.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- activation_type, word_type and byte_type already live in tpu_pkg.
- Add to tpu_pkg: activation_instr_type, a packed struct {acc_addr, buffer_addr, length, function, signed}.
- Add to tpu_pkg: an act_ctrl_state_type enum (IDLE, ISSUE, DRAIN, DONE).
- One sub-module is natural: act_ctrl_delay_pipe, a parameterised valid+address shift register of depth PIPE.

Test Plan:
- Reset, then length=4, acc=10, buf=100, relu, signed:
  - acc_rd_addr = 10,11,12,13 on consecutive cycles.
  - buf_wr_addr = 100..103, each exactly 3 cycles after its read.
  - done pulses 8 cycles after accept.
- length=0, sigmoid: no acc_rd_en and no buf_wr_en; done pulses 1 cycle after accept; instr_ready returns next cycle.
- Wrap: acc=510, buf=4094, length=4 → reads 510,511,0,1; writes 4094,4095,0,1.
- Second instruction offered mid-ISSUE → instr_ready=0 and it is ignored; it is accepted only after done, with its own function latched.
- rst asserted low during DRAIN of length=8 → all outputs at reset values immediately; no further writes; a new instruction is accepted after release.
- With ACTIVATION_CONTROL_PERF_EN, two instructions of length 5 and 3 → perf_rows=8 and perf_busy_cycles=16 (PIPE=3).
